// File: rtl/fft_addr_gen.sv
// Radix-2 in-place FFT address generator: issues N/2 butterfly reads per level
// and replays the operand addresses as write addresses after the butterfly latency.
module fft_addr_gen #(
    parameter int FFT_SIZE     = 4096,
    parameter int BFLY_LATENCY = 6,
    localparam int LEVELS      = $clog2(FFT_SIZE),
    localparam int LW          = $clog2(LEVELS),
    localparam int AW          = LEVELS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          addr_gen_go,
    input  logic [LW-1:0] fft_level,
    output logic          addr_gen_busy,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic [AW-2:0] tw_addr,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr_a,
    output logic [AW-1:0] wr_addr_b,
    output logic          fft_data_valid
);

    // state | meaning
    // IDLE  | waiting for addr_gen_go; earlier butterflies may still be draining
    // RUN   | one butterfly read issued per cycle, b = 0 .. N/2-1
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [AW-2:0] B_LAST = (AW-1)'(FFT_SIZE / 2 - 1);

    state_t        state_q, state_d;
    logic [AW-2:0] b_q, b_d;
    logic [LW-1:0] lvl_q, lvl_d;

    logic [AW-1:0] b_ext;
    logic [AW-1:0] mask;
    logic [AW-1:0] hi_part;
    logic [AW-1:0] addr_a_raw;
    logic [AW-1:0] addr_b_raw;
    logic [LW-1:0] tw_shift;
    logic [AW-2:0] tw_raw;

    logic [BFLY_LATENCY-1:0] dl_v;
    logic [AW-1:0]           dl_a [BFLY_LATENCY];
    logic [AW-1:0]           dl_b [BFLY_LATENCY];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            b_q     <= '0;
            lvl_q   <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            lvl_q   <= lvl_d;
        end
    end

    // A go seen while RUN is dropped; b holds at its last value once the level ends.
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        lvl_d   = lvl_q;
        case (state_q)
            IDLE: begin
                if (addr_gen_go) begin
                    state_d = RUN;
                    b_d     = '0;
                    lvl_d   = fft_level;
                end
            end
            RUN: begin
                if (b_q == B_LAST) begin
                    state_d = IDLE;
                end else begin
                    b_d = b_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign addr_gen_busy = (state_q == RUN);
    assign rd_en         = addr_gen_busy;

    // Operand A inserts a zero bit at position L into b; operand B sets that bit.
    always_comb begin
        b_ext      = AW'(b_q);
        mask       = (AW'(1) << lvl_q) - AW'(1);
        hi_part    = (b_ext >> lvl_q) << lvl_q;
        addr_a_raw = (hi_part << 1) | (b_ext & mask);
        addr_b_raw = addr_a_raw + (AW'(1) << lvl_q);
        tw_shift   = LW'(LEVELS - 1) - lvl_q;
        tw_raw     = (b_q & mask[AW-2:0]) << tw_shift;
    end

    // Addresses are parked at zero whenever no read is being issued.
    assign rd_addr_a = rd_en ? addr_a_raw : '0;
    assign rd_addr_b = rd_en ? addr_b_raw : '0;
    assign tw_addr   = rd_en ? tw_raw     : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dl_v <= '0;
            for (int i = 0; i < BFLY_LATENCY; i++) begin
                dl_a[i] <= '0;
                dl_b[i] <= '0;
            end
        end else begin
            dl_v[0] <= rd_en;
            dl_a[0] <= rd_addr_a;
            dl_b[0] <= rd_addr_b;
            for (int i = 1; i < BFLY_LATENCY; i++) begin
                dl_v[i] <= dl_v[i-1];
                dl_a[i] <= dl_a[i-1];
                dl_b[i] <= dl_b[i-1];
            end
        end
    end

    assign wr_en          = dl_v[BFLY_LATENCY-1];
    assign wr_addr_a      = dl_a[BFLY_LATENCY-1];
    assign wr_addr_b      = dl_b[BFLY_LATENCY-1];
    assign fft_data_valid = rd_en | (|dl_v);

endmodule

// File: tb/tb_fft_addr_gen.sv
// Directed bench for fft_addr_gen at N=16, butterfly latency 6.
module tb_fft_addr_gen;

    localparam int N   = 16;
    localparam int LAT = 6;

    logic       clk;
    logic       rst_n;
    logic       go;
    logic [1:0] level;
    logic       busy, rd_en, wr_en, valid;
    logic [3:0] rd_a, rd_b, wr_a, wr_b;
    logic [2:0] tw;

    int n_assert = 0;
    int n_fail   = 0;
    int rd_cnt;
    int wr_cnt;
    int cyc;

    fft_addr_gen #(.FFT_SIZE(N), .BFLY_LATENCY(LAT)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .addr_gen_go   (go),
        .fft_level     (level),
        .addr_gen_busy (busy),
        .rd_en         (rd_en),
        .rd_addr_a     (rd_a),
        .rd_addr_b     (rd_b),
        .tw_addr       (tw),
        .wr_en         (wr_en),
        .wr_addr_a     (wr_a),
        .wr_addr_b     (wr_b),
        .fft_data_valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while (valid && k < 40) begin
            step();
            k++;
        end
        chk(tag, {31'd0, valid}, 32'd0);
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        go    = 1'b0;
        level = 2'd0;
        #23;
        chk("rst_busy",  {31'd0, busy},  0);
        chk("rst_rd_en", {31'd0, rd_en}, 0);
        chk("rst_wr_en", {31'd0, wr_en}, 0);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_rd_a",  {28'd0, rd_a},  0);
        chk("rst_rd_b",  {28'd0, rd_b},  0);
        chk("rst_tw",    {29'd0, tw},    0);
        chk("rst_wr_a",  {28'd0, wr_a},  0);
        chk("rst_wr_b",  {28'd0, wr_b},  0);
        rst_n = 1'b1;
        step();
        chk("idle_busy", {31'd0, busy}, 0);

        // Level 0: reads at c=0..7, writes at c=6..13, valid through c=13.
        go = 1'b1; level = 2'd0;
        step();
        go = 1'b0;
        for (int c = 0; c <= 14; c++) begin
            chk($sformatf("l0_rd_en_c%0d", c), {31'd0, rd_en}, (c < 8) ? 1 : 0);
            chk($sformatf("l0_busy_c%0d", c),  {31'd0, busy},  (c < 8) ? 1 : 0);
            chk($sformatf("l0_valid_c%0d", c), {31'd0, valid}, (c < 14) ? 1 : 0);
            chk($sformatf("l0_wr_en_c%0d", c), {31'd0, wr_en}, (c >= 6 && c < 14) ? 1 : 0);
            if (c < 8) begin
                chk($sformatf("l0_rd_a_c%0d", c), {28'd0, rd_a}, 2 * c);
                chk($sformatf("l0_rd_b_c%0d", c), {28'd0, rd_b}, 2 * c + 1);
                chk($sformatf("l0_tw_c%0d", c),   {29'd0, tw},   0);
            end
            if (c >= 6 && c < 14) begin
                chk($sformatf("l0_wr_a_c%0d", c), {28'd0, wr_a}, 2 * (c - 6));
                chk($sformatf("l0_wr_b_c%0d", c), {28'd0, wr_b}, 2 * (c - 6) + 1);
            end
            step();
        end
        wait_drain("l0_drain");

        // Level 2: b=0 -> (0,4,0), b=5 -> (9,13,2).
        go = 1'b1; level = 2'd2;
        step();
        go = 1'b0;
        chk("l2_b0_rd_a", {28'd0, rd_a}, 0);
        chk("l2_b0_rd_b", {28'd0, rd_b}, 4);
        chk("l2_b0_tw",   {29'd0, tw},   0);
        for (int c = 0; c < 5; c++) step();
        chk("l2_b5_rd_en", {31'd0, rd_en}, 1);
        chk("l2_b5_rd_a",  {28'd0, rd_a},  9);
        chk("l2_b5_rd_b",  {28'd0, rd_b},  13);
        chk("l2_b5_tw",    {29'd0, tw},    2);
        step();
        chk("l2_b6_rd_a", {28'd0, rd_a}, 10);
        chk("l2_b6_tw",   {29'd0, tw},   4);
        wait_drain("l2_drain");

        // Level 3 with a stray go at b=3 that must be ignored.
        go = 1'b1; level = 2'd3;
        step();
        go = 1'b0;
        rd_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (rd_en) rd_cnt++;
            if (c == 3) begin
                go = 1'b1; level = 2'd0;
            end else begin
                go = 1'b0;
            end
            if (c == 4) begin
                chk("l3_b4_rd_a", {28'd0, rd_a}, 4);
                chk("l3_b4_rd_b", {28'd0, rd_b}, 12);
                chk("l3_b4_tw",   {29'd0, tw},   4);
            end
            if (c == 7) begin
                chk("l3_b7_rd_a", {28'd0, rd_a}, 7);
                chk("l3_b7_rd_b", {28'd0, rd_b}, 15);
                chk("l3_b7_tw",   {29'd0, tw},   7);
            end
            if (c == 8) chk("l3_busy_end", {31'd0, busy}, 0);
            step();
        end
        go = 1'b0;
        chk("l3_rd_count", rd_cnt, 8);
        wait_drain("l3_drain");

        // Back-to-back: level 1, then level 0 go on the cycle busy falls.
        go = 1'b1; level = 2'd1;
        step();
        go = 1'b0;
        for (int c = 0; c <= 15; c++) begin
            if (c == 8) begin
                chk("b2b_busy_fall", {31'd0, busy}, 0);
                go = 1'b1; level = 2'd0;
            end else begin
                go = 1'b0;
            end
            if (c == 9) begin
                chk("b2b_rd_en",  {31'd0, rd_en}, 1);
                chk("b2b_rd_a",   {28'd0, rd_a},  0);
                chk("b2b_rd_b",   {28'd0, rd_b},  1);
            end
            if (c == 13) begin
                chk("b2b_last_wr_en", {31'd0, wr_en}, 1);
                chk("b2b_last_wr_a",  {28'd0, wr_a},  13);
                chk("b2b_last_wr_b",  {28'd0, wr_b},  15);
            end
            if (c == 14) begin
                chk("b2b_gap_wr_en", {31'd0, wr_en}, 0);
                chk("b2b_gap_valid", {31'd0, valid}, 1);
            end
            if (c == 15) begin
                chk("b2b_new_wr_en", {31'd0, wr_en}, 1);
                chk("b2b_new_wr_a",  {28'd0, wr_a},  0);
            end
            step();
        end
        go = 1'b0;
        wait_drain("b2b_drain");

        // Reset asserted at b=4 of level 1.
        go = 1'b1; level = 2'd1;
        step();
        go = 1'b0;
        for (int c = 0; c < 4; c++) step();
        chk("pre_rst_rd_a", {28'd0, rd_a}, 8);
        chk("pre_rst_rd_b", {28'd0, rd_b}, 10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  {31'd0, busy},  0);
        chk("mid_rst_rd_en", {31'd0, rd_en}, 0);
        chk("mid_rst_wr_en", {31'd0, wr_en}, 0);
        chk("mid_rst_valid", {31'd0, valid}, 0);
        chk("mid_rst_rd_a",  {28'd0, rd_a},  0);
        step();
        step();
        rst_n = 1'b1;
        rd_cnt = 0;
        wr_cnt = 0;
        for (cyc = 0; cyc < 20; cyc++) begin
            step();
            if (rd_en) rd_cnt++;
            if (wr_en) wr_cnt++;
        end
        chk("post_rst_rd_count", rd_cnt, 0);
        chk("post_rst_wr_count", wr_cnt, 0);
        chk("post_rst_valid", {31'd0, valid}, 0);

        go = 1'b1; level = 2'd3;
        step();
        go = 1'b0;
        chk("resume_rd_en", {31'd0, rd_en}, 1);
        chk("resume_rd_b",  {28'd0, rd_b},  8);
        wait_drain("resume_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_addr_gen.md
FFT_ADDR_GEN -- requirements
Module: fft_addr_gen

Interface
REQ-001 SHALL have parameter FFT_SIZE, default 4096, transform length N (power of two, >= 4).
REQ-002 SHALL have parameter BFLY_LATENCY, default 6, cycles from read issue to butterfly result at the write port.
REQ-003 SHALL define derived widths: LW = clog2(clog2(N)), AW = clog2(N).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port addr_gen_go, input, 1, one-cycle start pulse for one FFT level.
REQ-007 SHALL have port fft_level, input, LW, level index 0..LEVELS-1 (LEVELS = clog2(N)), sampled on go.
REQ-008 SHALL have port addr_gen_busy, output, 1, high while butterfly reads are being issued.
REQ-009 SHALL have port rd_en, output, 1, read strobe for the read bank.
REQ-010 SHALL have ports rd_addr_a and rd_addr_b, output, AW each, butterfly operand read addresses.
REQ-011 SHALL have port tw_addr, output, AW-1, twiddle ROM index.
REQ-012 SHALL have port wr_en, output, 1, write strobe for the write bank.
REQ-013 SHALL have ports wr_addr_a and wr_addr_b, output, AW each, result write addresses.
REQ-014 SHALL have port fft_data_valid, output, 1, high while any issued butterfly is still in flight.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and RUN.
REQ-016 In IDLE with addr_gen_go high: next cycle RUN, latch fft_level into lvl_q, clear butterfly counter b to 0.
REQ-017 addr_gen_go while in RUN SHALL be ignored; lvl_q and b are unchanged.
REQ-018 In RUN: rd_en = 1 each cycle, b increments by 1; at b = N/2-1, next state IDLE and b holds.
REQ-019 addr_gen_busy SHALL equal (state == RUN), giving exactly N/2 consecutive rd_en cycles per go, the first one cycle after go.
REQ-020 Address map for level L = lvl_q: rd_addr_a = ((b >> L) << (L+1)) | (b & (2^L - 1)); rd_addr_b = rd_addr_a + 2^L.
REQ-021 Twiddle index SHALL be tw_addr = (b & (2^L - 1)) << (LEVELS-1-L), truncated to AW-1 bits.
REQ-022 rd_addr_a, rd_addr_b and tw_addr SHALL be driven from registered b and lvl_q, valid in the same cycle as rd_en; they are don't-care when rd_en is low.
REQ-023 A BFLY_LATENCY-deep shift register SHALL carry {rd_en, rd_addr_a, rd_addr_b}.
REQ-024 wr_en, wr_addr_a and wr_addr_b SHALL equal rd_en, rd_addr_a and rd_addr_b delayed by exactly BFLY_LATENCY cycles.
REQ-025 fft_data_valid SHALL be the OR of rd_en and every valid bit in the delay line, so it stays high until the last wr_en cycle has completed.
REQ-026 fft_data_valid SHALL drop low the cycle after the last wr_en.
REQ-027 A go accepted on the cycle addr_gen_busy falls SHALL start a new level while the previous level drains; the delay line is not flushed.
REQ-028 Input samples SHALL already be in bit-reversed order in memory; the block performs no bit reversal.

Reset
REQ-029 While reset is low, the block SHALL asynchronously force: state IDLE; b, lvl_q and all delay-line bits to 0; addr_gen_busy, rd_en, wr_en and fft_data_valid to 0.
REQ-030 Reset SHALL force all address outputs to 0.
REQ-031 Reset asserted mid-RUN SHALL abort the level with no further rd_en or wr_en; operation resumes only on a new go after release.

Verification (N = 16, BFLY_LATENCY = 6)
REQ-032 Bench SHALL cover: go at level 0 -> rd_en high exactly 8 cycles; (a,b,tw) = (0,1,0), (2,3,0), ... (14,15,0); busy high the same 8 cycles.
REQ-033 Bench SHALL cover: go at level 2, b = 5 -> rd_addr_a = 9, rd_addr_b = 13, tw_addr = 2.
REQ-034 Bench SHALL cover: go at level 3, b = 7 -> rd_addr_a = 7, rd_addr_b = 15, tw_addr = 7.
REQ-035 Bench SHALL cover: first rd_en at cycle t -> first wr_en at t+6 with matching addresses; fft_data_valid high t..t+13 and low at t+14.
REQ-036 Bench SHALL cover: second go pulse at b = 3 -> ignored; sequence continues to b = 7 with total rd_en count 8.
REQ-037 Bench SHALL cover: reset low at b = 4 -> busy, rd_en, wr_en and fft_data_valid low immediately; no writes after release until a new go.
